// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer. It handles one SRL/SLL/SRA request at a time
// and moves an internal accumulator by at most STEP bit positions per clock.
// Completion is reported by a one-cycle done pulse, and the result is held in
// shifter_result. The op encoding is the same as the ALU shift ops.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; busy=0
//   SHIFT | stepping acc by min(remaining, STEP) each cycle
//   DONE  | one-cycle completion: done=1, result already registered
module shift_seq_ctrl #(
    parameter int OPD_LENGTH = 32,
    parameter int STEP       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [OPD_LENGTH-1:0] opd1,
    input  logic [OPD_LENGTH-1:0] opd2,
    input  logic [2:0]            alu_op_select,
    output logic                  busy,
    output logic                  done,
    output logic                  invalid_op,
    output logic [OPD_LENGTH-1:0] shifter_result
);

    localparam int SHW = $clog2(OPD_LENGTH);
    // remaining carries one extra bit so that it can hold OPD_LENGTH
    // and so that subtracting k <= remaining can never wrap.
    localparam int RW  = SHW + 1;
    localparam logic [RW-1:0] STEP_C = RW'(STEP);

    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [OPD_LENGTH-1:0] acc;
    logic [OPD_LENGTH-1:0] acc_next;
    logic [RW-1:0]         remaining;
    logic [RW-1:0]         rem_next;
    logic [RW-1:0]         step_amt;
    logic [2:0]            op_q;
    logic                  op_valid;

    // Only the low log2(OPD_LENGTH) bits of the shift amount matter.
    logic unused_opd2_bits;
    assign unused_opd2_bits = ^opd2[OPD_LENGTH-1:SHW];

    // Decode the incoming op code. Only the three shift encodings are accepted.
    always_comb begin
        op_valid = (alu_op_select == OP_SRL) ||
                   (alu_op_select == OP_SLL) ||
                   (alu_op_select == OP_SRA);
    end

    // Work out one shift step: k = min(remaining, STEP), then apply it to acc.
    always_comb begin
        step_amt = (remaining < STEP_C) ? remaining : STEP_C;
        rem_next = remaining - step_amt;
        case (op_q)
            OP_SRL:  acc_next = acc >> step_amt;
            OP_SLL:  acc_next = acc << step_amt;
            OP_SRA:  acc_next = OPD_LENGTH'($signed(acc) >>> step_amt);
            default: acc_next = acc;
        endcase
    end

    // Sequencer FSM. All outputs are registered and are updated on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            acc            <= '0;
            remaining      <= '0;
            op_q           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            invalid_op     <= 1'b0;
            shifter_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    invalid_op <= 1'b0;
                    if (start) begin
                        if (op_valid) begin
                            acc       <= opd1;
                            remaining <= {1'b0, opd2[SHW-1:0]};
                            op_q      <= alu_op_select;
                            busy      <= 1'b1;
                            state     <= SHIFT;
                        end else begin
                            // A rejected op goes straight to DONE and leaves acc untouched.
                            busy           <= 1'b1;
                            done           <= 1'b1;
                            invalid_op     <= 1'b1;
                            shifter_result <= '0;
                            state          <= DONE;
                        end
                    end
                end

                SHIFT: begin
                    // A shift amount of zero still takes this state for one cycle, with k=0.
                    acc       <= acc_next;
                    remaining <= rem_next;
                    if (rem_next == '0) begin
                        done           <= 1'b1;
                        shifter_result <= acc_next;
                        state          <= DONE;
                    end
                end

                DONE: begin
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    invalid_op <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    invalid_op <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
